// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on an inferred simple dual-port RAM with occupancy count,
// programmable almost flags, sticky error flags and an optional fall-through output.
module sync_fifo_ram #(
  parameter int SIZE   = 8,
  parameter int DEPTH  = 16,
  parameter int FWFT   = 0,
  parameter int AFULL  = DEPTH - 2,
  parameter int AEMPTY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SIZE-1:0]        din,
  input  logic                   wput,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   rget,
  output logic [SIZE-1:0]        dout,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic            push_ok;
  logic            pop_ok;
  logic            ram_rd;   // RAM read strobe; the read pointer advances with it

  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign push_ok      = wput & ~full;
  assign pop_ok       = rget & ~empty;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + PTR_ONE;
      if (ram_rd)  rp <= rp + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wput & full)  overflow  <= 1'b1;
      if (rget & empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      assign ram_rd = pop_ok;
      assign empty  = (count == '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout <= '0;
        else if (pop_ok) dout <= mem[rp];
      end
    end else begin : g_fwft
      logic ov;
      logic ram_avail;

      // count includes the word parked in dout, so the RAM holds count - ov unread words.
      assign ram_avail = (count != {{AW{1'b0}}, ov});
      assign ram_rd    = ram_avail & (~ov | pop_ok);
      assign empty     = ~ov;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov   <= 1'b0;
          dout <= '0;
        end else if (ram_rd) begin
          dout <= mem[rp];
          ov   <= 1'b1;
        end else if (pop_ok) begin
          ov   <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: doc/sync_fifo_ram.md
# sync_fifo_ram

Single-clock, parametrised FIFO built on an inferred simple dual-port block RAM, with occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) output mode. It is the general-purpose buffering element between producer and consumer logic in one clock domain, e.g. pixel-pattern generators feeding serialisers, or UART/command paths. Storage is described so the tools map large instances to block RAM.

## Interface
- SIZE, 8, width of each word in bits (≥1)
- DEPTH, 16, number of words; power of two, ≥4
- FWFT, 0, 0 = standard mode (dout valid one cycle after pop); 1 = first-word-fall-through (dout shows head word whenever !empty)
- AFULL, DEPTH-2, almost_full asserts when count ≥ AFULL (1..DEPTH)
- AEMPTY, 2, almost_empty asserts when count ≤ AEMPTY (0..DEPTH-1)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  SIZE  write data
- wput  in  1  push request; accepted iff wput & !full
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL
- rget  in  1  pop request; accepted iff rget & !empty
- dout  out  SIZE  read data
- empty  out  1  no word available to pop
- almost_empty  out  1  count ≤ AEMPTY
- count  out  $clog2(DEPTH)+1  words held (0..DEPTH)
- overflow  out  1  sticky: a wput was refused while full
- underflow  out  1  sticky: a rget was refused while empty

## Operation
- Storage: mem[DEPTH] of SIZE bits; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH naturally (DEPTH-1 → 0).
- Push accepted: mem[wp] <= din, wp <= wp+1. Pop accepted: rp <= rp+1.
- count: +1 on accepted push only, −1 on accepted pop only, unchanged on both or neither. Never exceeds DEPTH or drops below 0.
- full, almost_full, almost_empty are combinational from registered count. Refused push leaves memory, wp, count unchanged; refused pop leaves rp, count, dout unchanged.
- Full + wput + rget: pop accepted, push refused (no pass-through), overflow sets. Empty + wput + rget: push accepted, pop refused, underflow sets.
- FWFT=0: empty = (count == 0). Accepted pop registers mem[rp] into dout; dout holds otherwise.
- FWFT=1: internal output register with valid bit ov; count includes the word held in it. When !ov or (ov & accepted pop), and RAM holds an unread word, load mem[rp] into dout and set ov; else accepted pop clears ov. empty = !ov.
- overflow/underflow clear only on reset.

## Timing
- Reset (rst_n low, any time, independent of clk): wp=rp=0, count=0, dout=0, ov=0, full=0, almost_full=(AFULL==0 → never; effectively 0), empty=1, almost_empty=1, overflow=0, underflow=0. Mid-operation reset discards all contents; RAM contents need not clear. Deassertion is expected synchronous to clk (reset conditioner upstream).
- Push latency to count/flags: count updates at the accepting edge.
- FWFT=0: write at edge N → empty low after N; rget at edge M → dout valid after M (one-cycle read latency).
- FWFT=1: write into empty FIFO at edge N → RAM read at N+1, dout valid and empty low after N+1 (two-edge latency); count=1 already after N. Back-to-back pops at one per cycle sustain full throughput with dout updated each edge.
- Writes and reads never target the same RAM word in the same cycle except when count==0 (standard) — read is then refused, so no read-during-write hazard.

## Test plan
- Reset: hold rst_n=0 with random wput/rget → empty=1, full=0, count=0, dout=0, overflow=underflow=0; release, idle → unchanged.
- Fill/drain, DEPTH=16, FWFT=0: push 0x00..0x0F → full=1, count=16, almost_full from count=14; pop 16 → dout 0x00..0x0F each one cycle after rget, empty=1 after last.
- Overflow/underflow: full FIFO, wput din=0xAA → count stays 16, overflow=1, 0xAA never read; empty FIFO, rget → underflow=1, dout unchanged.
- Simultaneous: count=5, wput+rget for 40 cycles with incrementing data → count stays 5, pointers wrap past 15, output sequence in order with no gaps.
- FWFT=1: push 0x3C into empty at edge N → empty low and dout=0x3C after N+1; rget at next edge with second word present → dout advances to it immediately, empty stays 0.
- Mid-operation reset: count=9, pulse rst_n low between edges → all outputs reset values immediately; subsequent push 0x55 then pop returns 0x55.
